// File: rtl/fitness_pkg.sv
// Shared types and constants for the fitness timer blocks: FSM states and
// the mm:ss field widths that match the exercise calculator output.
package fitness_pkg;

  localparam int SEC_PER_MIN = 60;
  localparam int MIN_W       = 9;
  localparam int SEC_W       = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // States in which a new minute count may be taken
  function automatic logic accepts_load(input state_t s);
    return (s == IDLE) || (s == LOADED) || (s == DONE);
  endfunction

endpackage

// File: rtl/exercise_countdown_timer_sec_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled and flags
// the cycle in which it wraps; holds its value while disabled.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exercise_countdown_timer.sv
// Exercise countdown timer: loads a minute count, counts it down as mm:ss at
// 1 Hz with start/pause/abort control and pulses done on reaching 0:00.
module exercise_countdown_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MIN_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [MIN_W-1:0] minutes_in,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [MIN_W-1:0] min_left,
  output logic [5:0]       sec_left,
  output logic [2:0]       state_o,
  output logic             running,
  output logic             done
);

  import fitness_pkg::*;

  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_PER_MIN - 1);

  state_t           r_state, w_state_next;
  logic [MIN_W-1:0] r_min, w_min_next, w_dec_min;
  logic [SEC_W-1:0] r_sec, w_sec_next, w_dec_sec;
  logic             r_done, w_done_next;
  logic             w_tick, w_presc_en, w_presc_clr, w_dec_zero, w_take_load;

  assign w_presc_en = (r_state == RUN);

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_presc_en),
    .i_clr (w_presc_clr),
    .o_tick(w_tick)
  );

  // One-second decrement of mm:ss; 0:00 is held rather than wrapped
  always_comb begin
    w_dec_min = r_min;
    w_dec_sec = r_sec;
    if (r_sec != '0) begin
      w_dec_sec = r_sec - SEC_W'(1);
    end else if (r_min != '0) begin
      w_dec_sec = SEC_MAX;
      w_dec_min = r_min - MIN_W'(1);
    end
  end

  assign w_dec_zero = (w_dec_min == '0) && (w_dec_sec == '0);

  always_comb begin
    w_state_next = r_state;
    w_min_next   = r_min;
    w_sec_next   = r_sec;
    w_done_next  = 1'b0;
    w_presc_clr  = 1'b0;
    w_take_load  = 1'b0;
    if (abort) begin
      w_state_next = IDLE;
      w_min_next   = '0;
      w_sec_next   = '0;
      w_presc_clr  = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_tick) begin
            w_min_next = w_dec_min;
            w_sec_next = w_dec_sec;
            // Completion wins over a coincident pause
            if (w_dec_zero) begin
              w_state_next = DONE;
              w_done_next  = 1'b1;
            end else if (pause) begin
              w_state_next = PAUSE;
            end
          end else if (pause) begin
            w_state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (start) w_state_next = RUN;
        end
        LOADED: begin
          if (start) begin
            w_state_next = RUN;
            w_presc_clr  = 1'b1;
          end else if (load_valid) begin
            w_take_load = 1'b1;
          end
        end
        default: begin
          if (load_valid) w_take_load = 1'b1;
        end
      endcase
    end

    if (w_take_load) begin
      w_presc_clr = 1'b1;
      w_sec_next  = '0;
      if (minutes_in != '0) begin
        w_min_next   = minutes_in;
        w_state_next = LOADED;
      end else begin
        w_min_next   = '0;
        w_state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_min   <= '0;
      r_sec   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_min   <= w_min_next;
      r_sec   <= w_sec_next;
      r_done  <= w_done_next;
    end
  end

  assign min_left   = r_min;
  assign sec_left   = r_sec;
  assign state_o    = r_state;
  assign running    = (r_state == RUN);
  assign done       = r_done;
  assign load_ready = accepts_load(r_state);

endmodule

// File: tb/tb_exercise_countdown_timer.sv
// Scoreboard bench for exercise_countdown_timer at TICKS_PER_SEC=4: stimulus
// schedules expected observations by cycle; a negedge monitor compares them.
module tb_exercise_countdown_timer;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] mn;
    logic [5:0] sc;
    logic       rdy;
    logic       run;
    logic       dn;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [8:0] minutes_in;
  logic       start;
  logic       pause;
  logic       abort;
  logic [8:0] min_left;
  logic [5:0] sec_left;
  logic [2:0] state_o;
  logic       running;
  logic       done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   q_at[$];
  string q_nm[$];
  obs_t q_v[$];
  int   done_q[$];

  exercise_countdown_timer #(
    .TICKS_PER_SEC(4),
    .MIN_W(9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .minutes_in(minutes_in),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .min_left  (min_left),
    .sec_left  (sec_left),
    .state_o   (state_o),
    .running   (running),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic sched(input int dly, input string nm, input logic [2:0] st,
                       input logic [8:0] mn, input logic [5:0] sc, input logic dn);
    obs_t o;
    o.st  = st;
    o.mn  = mn;
    o.sc  = sc;
    o.rdy = (st == 3'd0) || (st == 3'd1) || (st == 3'd4);
    o.run = (st == 3'd2);
    o.dn  = dn;
    q_at.push_back(cyc + dly);
    q_nm.push_back(nm);
    q_v.push_back(o);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares every expectation scheduled for this cycle, and
  // matches each done pulse against the expected-done queue.
  always @(negedge clk) begin
    obs_t act;
    int   idx;
    act.st  = state_o;
    act.mn  = min_left;
    act.sc  = sec_left;
    act.rdy = load_ready;
    act.run = running;
    act.dn  = done;
    for (int i = q_at.size() - 1; i >= 0; i--) begin
      if (q_at[i] == cyc) begin
        checks++;
        if (act !== q_v[i]) begin
          errors++;
          $display("FAIL %s cyc=%0d got st=%0d %0d:%0d rdy=%0b run=%0b done=%0b want st=%0d %0d:%0d rdy=%0b run=%0b done=%0b",
                   q_nm[i], cyc, act.st, act.mn, act.sc, act.rdy, act.run, act.dn,
                   q_v[i].st, q_v[i].mn, q_v[i].sc, q_v[i].rdy, q_v[i].run, q_v[i].dn);
        end else begin
          $display("ok   %s cyc=%0d st=%0d %0d:%0d done=%0b", q_nm[i], cyc, act.st, act.mn, act.sc, act.dn);
        end
        q_at.delete(i);
        q_nm.delete(i);
        q_v.delete(i);
      end
    end
    if (done === 1'b1) begin
      idx = -1;
      checks++;
      for (int j = 0; j < done_q.size(); j++) if (done_q[j] == cyc) idx = j;
      if (idx < 0) begin
        errors++;
        $display("FAIL done_pulse cyc=%0d got done=1 want no pulse this cycle", cyc);
      end else begin
        done_q.delete(idx);
        $display("ok   done_pulse cyc=%0d", cyc);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    minutes_in = '0;
    start      = 1'b0;
    pause      = 1'b0;
    abort      = 1'b0;
    run_cycles(3);
    rst = 1'b0;
    sched(0, "reset", 3'd0, 9'd0, 6'd0, 1'b0);

    // Load 2, run to completion: done 480 RUN cycles after start
    load_valid = 1'b1; minutes_in = 9'd2;
    sched(1, "t1_load", 3'd1, 9'd2, 6'd0, 1'b0);
    step();
    load_valid = 1'b0; start = 1'b1;
    sched(1, "t1_start", 3'd2, 9'd2, 6'd0, 1'b0);
    step();
    start = 1'b0;
    sched(3,   "t1_pre_tick", 3'd2, 9'd2, 6'd0,  1'b0);
    sched(4,   "t1_1_59",     3'd2, 9'd1, 6'd59, 1'b0);
    sched(240, "t1_1_00",     3'd2, 9'd1, 6'd0,  1'b0);
    sched(476, "t1_0_01",     3'd2, 9'd0, 6'd1,  1'b0);
    sched(480, "t1_done",     3'd4, 9'd0, 6'd0,  1'b1);
    sched(481, "t1_hold",     3'd4, 9'd0, 6'd0,  1'b0);
    done_q.push_back(cyc + 480);
    run_cycles(482);

    // Load 2, pause at 1:30 for 100 cycles, resume: done 580 cycles after start
    load_valid = 1'b1; minutes_in = 9'd2;
    sched(1, "t2_load", 3'd1, 9'd2, 6'd0, 1'b0);
    step();
    load_valid = 1'b0; start = 1'b1;
    sched(1, "t2_start", 3'd2, 9'd2, 6'd0, 1'b0);
    step();
    start = 1'b0;
    done_q.push_back(cyc + 580);
    sched(580, "t2_done", 3'd4, 9'd0, 6'd0, 1'b1);
    sched(120, "t2_1_30", 3'd2, 9'd1, 6'd30, 1'b0);
    run_cycles(120);
    pause = 1'b1;
    sched(1,   "t2_pause",    3'd3, 9'd1, 6'd30, 1'b0);
    sched(51,  "t2_frozen_a", 3'd3, 9'd1, 6'd30, 1'b0);
    sched(100, "t2_frozen_b", 3'd3, 9'd1, 6'd30, 1'b0);
    step();
    run_cycles(49);
    pause = 1'b0;
    run_cycles(50);
    start = 1'b1;
    sched(1, "t2_resume", 3'd2, 9'd1, 6'd30, 1'b0);
    sched(4, "t2_1_29",   3'd2, 9'd1, 6'd29, 1'b0);
    step();
    start = 1'b0;
    run_cycles(360);

    // Load 3, load attempt in RUN, abort at 2:10, then load 0
    load_valid = 1'b1; minutes_in = 9'd3;
    sched(1, "t3_load", 3'd1, 9'd3, 6'd0, 1'b0);
    step();
    load_valid = 1'b0; start = 1'b1;
    sched(1, "t3_start", 3'd2, 9'd3, 6'd0, 1'b0);
    step();
    start = 1'b0;
    sched(200, "t3_2_10", 3'd2, 9'd2, 6'd10, 1'b0);
    run_cycles(200);
    load_valid = 1'b1; minutes_in = 9'd5;
    sched(1, "t3_load_in_run", 3'd2, 9'd2, 6'd10, 1'b0);
    step();
    load_valid = 1'b0; abort = 1'b1;
    sched(1, "t3_abort", 3'd0, 9'd0, 6'd0, 1'b0);
    step();
    abort = 1'b0; load_valid = 1'b1; minutes_in = 9'd0;
    sched(1, "t3_load0", 3'd0, 9'd0, 6'd0, 1'b0);
    step();
    load_valid = 1'b0; start = 1'b1;
    sched(1, "t3_start_idle", 3'd0, 9'd0, 6'd0, 1'b0);
    step();
    start = 1'b0;
    run_cycles(10);

    // Pause coincident with a tick at 1:01 and at 0:01
    load_valid = 1'b1; minutes_in = 9'd2;
    sched(1, "t4_load", 3'd1, 9'd2, 6'd0, 1'b0);
    step();
    load_valid = 1'b0; start = 1'b1;
    sched(1, "t4_start", 3'd2, 9'd2, 6'd0, 1'b0);
    step();
    start = 1'b0;
    sched(236, "t4_1_01", 3'd2, 9'd1, 6'd1, 1'b0);
    run_cycles(239);
    pause = 1'b1;
    sched(1, "t4_pause_tick", 3'd3, 9'd1, 6'd0, 1'b0);
    step();
    pause = 1'b0; start = 1'b1;
    sched(1, "t4_resume", 3'd2, 9'd1, 6'd0, 1'b0);
    step();
    start = 1'b0;
    sched(236, "t4_0_01", 3'd2, 9'd0, 6'd1, 1'b0);
    run_cycles(239);
    pause = 1'b1;
    done_q.push_back(cyc + 1);
    sched(1, "t4_pause_done", 3'd4, 9'd0, 6'd0, 1'b1);
    sched(2, "t4_done_once",  3'd4, 9'd0, 6'd0, 1'b0);
    step();
    pause = 1'b0;
    step();

    // start ignored in DONE, load 1 from DONE, load 511 and run
    start = 1'b1;
    sched(1, "t5_start_done", 3'd4, 9'd0, 6'd0, 1'b0);
    step();
    start = 1'b0; load_valid = 1'b1; minutes_in = 9'd1;
    sched(1, "t5_load1", 3'd1, 9'd1, 6'd0, 1'b0);
    step();
    minutes_in = 9'd511;
    sched(1, "t5_load511", 3'd1, 9'd511, 6'd0, 1'b0);
    step();
    load_valid = 1'b0; start = 1'b1;
    sched(1, "t5_start", 3'd2, 9'd511, 6'd0, 1'b0);
    step();
    start = 1'b0;
    sched(4, "t5_510_59", 3'd2, 9'd510, 6'd59, 1'b0);
    sched(8, "t5_510_58", 3'd2, 9'd510, 6'd58, 1'b0);
    run_cycles(9);

    // Asynchronous reset mid-run, observed before any further clock edge
    #2;
    rst = 1'b1;
    sched(0, "async_rst",  3'd0, 9'd0, 6'd0, 1'b0);
    sched(2, "rst_held",   3'd0, 9'd0, 6'd0, 1'b0);
    run_cycles(2);
    rst = 1'b0; load_valid = 1'b1; minutes_in = 9'd1;
    sched(1, "post_rst_load", 3'd1, 9'd1, 6'd0, 1'b0);
    step();
    load_valid = 1'b0;
    run_cycles(2);
    @(negedge clk);
    #1;

    for (int i = 0; i < q_at.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL %s never compared: scheduled cyc=%0d, run ended at cyc=%0d", q_nm[i], q_at[i], cyc);
    end
    for (int i = 0; i < done_q.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL done_missing got no pulse want done at cyc=%0d", done_q[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exercise_countdown_timer.md
Name: exercise_countdown_timer

Overview:
Consumer end of the exercise calculator's total_exercises output. Accepts a 9-bit minute count through a valid/ready load handshake and counts it down as mm:ss at a 1 Hz rate derived from the system clock. Supports start, pause/resume and abort, and emits a one-cycle done pulse at 0:00. Feeds the display and buzzer logic of the fitness timer.

Parameters:
TICKS_PER_SEC, 50_000_000, clock cycles per second tick (must be ≥2; benches use 4).
MIN_W, 9, minute width; matches the calculator output width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
load_valid  in  1  minutes_in is valid.
load_ready  out  1  timer can accept a load.
minutes_in  in  MIN_W  minutes to load (0..511).
start  in  1  start or resume request, level-sampled.
pause  in  1  pause request, level-sampled.
abort  in  1  cancel and clear.
min_left  out  MIN_W  remaining minutes.
sec_left  out  6  remaining seconds (0..59).
state_o  out  3  current FSM state encoding.
running  out  1  high in RUN.
done  out  1  one-cycle pulse on reaching 0:00.

Behaviour:
- Single clock domain. Every output is registered or decoded directly from the registered state. There is no combinational path from any input to any output.
- Reset values: state IDLE; min_left 0; sec_left 0; done 0; running 0; prescaler 0. load_ready is 1 after reset because the FSM is in IDLE.
- States: IDLE=0, LOADED=1, RUN=2, PAUSE=3, DONE=4.
- load_ready is 1 in IDLE, LOADED and DONE, and 0 in RUN and PAUSE.
- Load accept: load_valid && load_ready at a clock edge.
  - minutes_in ≠ 0: min_left←minutes_in, sec_left←0, state←LOADED.
  - minutes_in = 0: counters cleared, state←IDLE, no done pulse.
- start:
  - LOADED→RUN: prescaler cleared.
  - PAUSE→RUN: prescaler keeps its value.
  - Ignored in IDLE, RUN and DONE.
- pause: RUN→PAUSE. Prescaler and counters freeze. Ignored in every other state.
- abort: any state except IDLE →IDLE. Counters and prescaler cleared; no done pulse.
- Input priority within one cycle: abort > pause > start > load.
- Prescaler: counts 0..TICKS_PER_SEC-1 only while in RUN. The cycle in which it wraps from TICKS_PER_SEC-1 is a second tick.
- Second tick:
  - sec_left≠0: sec_left−1.
  - sec_left=0: sec_left←59 and min_left−1.
  - The 0:00 state is never decremented.
- Completion: if a tick produces 0:00, state←DONE and done=1 for exactly one cycle on the same edge.
  - DONE has priority over a simultaneous pause.
  - abort in the same cycle overrides completion: IDLE, and done stays 0.
- Tick coincident with pause (result not 0:00): the tick is applied, then state←PAUSE.
- Latency: for a load of M minutes, done asserts after exactly M·60·TICKS_PER_SEC clock edges in RUN, counted from the first RUN cycle. Cycles spent in PAUSE are not counted.
- DONE holds 0:00. A load moves to LOADED; abort moves to IDLE.
- Minute arithmetic is unsigned MIN_W bits and never underflows.
- Asynchronous reset mid-run returns all state to reset values immediately, independent of clk.

Decomposition:
- Shared package fitness_pkg holds:
  - state enum (IDLE, LOADED, RUN, PAUSE, DONE);
  - SEC_PER_MIN=60;
  - MIN_W=9, shared with the calculator;
  - SEC_W=6.
- One sub-module, sec_tick_gen: prescaler with enable and clear inputs, parameter TICKS_PER_SEC, output tick. The top level keeps the FSM and the mm:ss down-counter.

Test Plan (TICKS_PER_SEC=4):
- Reset asserted mid-run → min_left=0, sec_left=0, state_o=0, load_ready=1, done=0, with no clock edge required.
- Load 2, start → 2:00 →(4 cycles) 1:59 → … → 0:00. done pulses once, 480 RUN cycles after start; state_o=4; load_ready=1.
- Load 2, start, pause at 1:30 held 100 cycles → outputs frozen during pause. Resume → done at 480 RUN cycles; 580 total cycles if pause and start are single-cycle.
- Load 3, start, abort at 2:10 → IDLE, 0:00, done never asserts. Then load 0 → remains IDLE, no done.
- Load 5 presented in RUN → load_ready=0, no change. pause and tick in the same cycle at 1:01 → 1:00 and state PAUSE. pause and tick at 0:01 → DONE with done=1.
- Load 511, start → after 4 cycles 510:59. start re-asserted in DONE is ignored. Load 1 in DONE → LOADED at 1:00.
